// File: rtl/mfp_ahb_vram_paged.sv
`default_nettype none
// =============================================================================
// mfp_ahb_vram_paged : paged AHB-Lite framebuffer with a VGA scan-out port
// Revision 1.0 - initial release
// =============================================================================
module mfp_ahb_vram_paged #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 19,
  parameter int PAGES  = 2,
  localparam int PW    = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W:0]   HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  input  logic [ADDR_W-1:0] IO_VGA_ADDR,
  input  logic              IO_VGA_VSYNC,
  output logic [DATA_W-1:0] IO_VGA_DATA,
  output logic [PW-1:0]     FRONT_PAGE,
  output logic              FLIP_PENDING
);

  localparam int AW    = (PAGES > 1) ? ADDR_W + PW : ADDR_W;
  localparam int DEPTH = PAGES * (2 ** ADDR_W);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              accept;
  logic              pix_re;
  logic              wr_phase;
  logic              pix_we;
  logic              ctl_we;
  logic              conflict;
  logic              stalled;
  logic              wr_done;
  logic              dp_valid;
  logic              dp_write;
  logic              dp_ctrl;
  logic [ADDR_W-1:0] dp_addr;
  logic [PW-1:0]     dp_page;
  logic [PW-1:0]     back;
  logic [PW-1:0]     front;
  logic [PW-1:0]     req_front;
  logic              pending;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] vga_q;
  logic [DATA_W-1:0] ctrl_word;
  logic              unused_bits;

  function automatic logic [AW-1:0] mem_idx(input logic [PW-1:0] page,
                                            input logic [ADDR_W-1:0] addr);
    logic [PW+ADDR_W-1:0] full;
    full = {page, addr};
    return full[AW-1:0];
  endfunction

  function automatic logic [PW-1:0] wrap_page(input logic [PW-1:0] p);
    return (PAGES == 1) ? '0 : p;
  endfunction

  assign accept   = HRESETn & HSEL & HTRANS[1] & HREADY;
  assign pix_re   = accept & ~HWRITE & ~HADDR[ADDR_W];
  assign wr_phase = HRESETn & dp_valid & dp_write & ~wr_done;
  assign pix_we   = wr_phase & ~dp_ctrl;
  assign ctl_we   = wr_phase & dp_ctrl;

  // A pixel read cannot share the AHB RAM port with a pixel write data phase:
  // hold the bus for one cycle so the read is issued after the write lands.
  assign conflict = HRESETn & dp_valid & dp_write & ~dp_ctrl & ~stalled &
                    HSEL & HTRANS[1] & ~HWRITE & ~HADDR[ADDR_W];

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_ctrl  <= 1'b0;
      dp_addr  <= '0;
      dp_page  <= '0;
      stalled  <= 1'b0;
      wr_done  <= 1'b0;
    end else begin
      stalled <= conflict;
      if (HREADY) begin
        wr_done  <= 1'b0;
        dp_valid <= accept;
        if (accept) begin
          dp_write <= HWRITE;
          dp_ctrl  <= HADDR[ADDR_W];
          dp_addr  <= HADDR[ADDR_W-1:0];
          dp_page  <= back;
        end
      end else if (wr_phase) begin
        wr_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (pix_we) mem[mem_idx(dp_page, dp_addr)] <= HWDATA;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) ram_q <= '0;
    else if (pix_re) ram_q <= mem[mem_idx(back, HADDR[ADDR_W-1:0])];
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) vga_q <= '0;
    else vga_q <= mem[mem_idx(front, IO_VGA_ADDR)];
  end

  // A flip request written in a VSYNC cycle is kept for the next frame.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      front     <= '0;
      back      <= (PAGES > 1) ? PW'(1) : '0;
      req_front <= '0;
      pending   <= 1'b0;
    end else begin
      if (ctl_we) back <= wrap_page(HWDATA[PW-1:0]);
      if (ctl_we && HWDATA[2*PW]) begin
        req_front <= wrap_page(HWDATA[2*PW-1:PW]);
        pending   <= 1'b1;
      end else if (IO_VGA_VSYNC && pending) begin
        front   <= req_front;
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    ctrl_word             = '0;
    ctrl_word[PW-1:0]     = back;
    ctrl_word[2*PW-1:PW]  = front;
    ctrl_word[2*PW]       = pending;
  end

  assign HRDATA       = dp_ctrl ? ctrl_word : ram_q;
  assign HREADYOUT    = ~conflict;
  assign HRESP        = 1'b0;
  assign IO_VGA_DATA  = vga_q;
  assign FRONT_PAGE   = front;
  assign FLIP_PENDING = pending;

  assign unused_bits  = ^{HTRANS[0], HWDATA};

endmodule
`default_nettype wire

// File: doc/mfp_ahb_vram_paged.md
MFP_AHB_VRAM_PAGED -- requirements
Module: mfp_ahb_vram_paged

Interface
REQ-001 Parameter DATA_W, 12, pixel width in bits (1..32).
REQ-002 Parameter ADDR_W, 19, pixel address width within one page.
REQ-003 Parameter PAGES, 2, framebuffer page count (1, 2 or 4); PW = max(1, clog2(PAGES)).
REQ-004 HCLK  in  1  sole clock; all logic on rising edge.
REQ-005 HRESETn  in  1  reset, synchronous, active-low.
REQ-006 HSEL  in  1  AHB-Lite slave select.
REQ-007 HADDR  in  ADDR_W+1  bit ADDR_W=0: pixel; bit ADDR_W=1: control register.
REQ-008 HTRANS  in  2  AHB transfer type.
REQ-009 HWRITE  in  1  1 = write.
REQ-010 HWDATA  in  DATA_W  write data (data phase).
REQ-011 HREADY  in  1  bus-wide ready.
REQ-012 HRDATA  out  DATA_W  read data (data phase).
REQ-013 HREADYOUT  out  1  slave ready.
REQ-014 HRESP  out  1  tied 0 (OKAY).
REQ-015 IO_VGA_ADDR  in  ADDR_W  scan-out pixel address.
REQ-016 IO_VGA_VSYNC  in  1  one-cycle frame-start pulse.
REQ-017 IO_VGA_DATA  out  DATA_W  scan-out pixel, registered.
REQ-018 FRONT_PAGE  out  PW  page currently displayed.
REQ-019 FLIP_PENDING  out  1  flip requested, awaiting VSYNC.

Function
REQ-020 Storage SHALL be inferred dual-port RAM of PAGES*2^ADDR_W words of DATA_W; no vendor IP.
REQ-021 Transfer accepted when HSEL & HTRANS[1] & HREADY; address, HWRITE, region and back page registered for data phase.
REQ-022 Pixel write SHALL commit HWDATA to {back, addr_d} in its data phase, exactly once even if data phase is extended.
REQ-023 Pixel read SHALL present mem[{back, HADDR}] on HRDATA in the following (data-phase) cycle; 0 wait states nominal.
REQ-024 Port conflict: accepted pixel read address phase coinciding with pixel write data phase -> HREADYOUT=0 for exactly one cycle; read issued next cycle from held HADDR; returns newly written data if same address.
REQ-025 Control register accesses and IDLE/BUSY transfers SHALL never insert wait states.
REQ-026 Control read SHALL return {0.., flip_pending, front, back}: back [PW-1:0], front [2PW-1:PW], pending bit 2PW.
REQ-027 Control write SHALL load back from HWDATA[PW-1:0]; if HWDATA[2PW]=1, load req_front from HWDATA[2PW-1:PW] and set pending.
REQ-028 New back page SHALL apply to transfers whose address phase follows the control write data phase.
REQ-029 IO_VGA_VSYNC=1 with pending=1: front<=req_front, pending<=0 same edge.
REQ-030 Flip request write and VSYNC in same cycle: request wins; front unchanged, pending=1, flip on next VSYNC.
REQ-031 IO_VGA_DATA SHALL equal mem[{front, IO_VGA_ADDR}] one cycle after address; independent of AHB activity.
REQ-032 Page index wraps modulo PAGES (values >= PAGES masked to PW bits; PAGES=1 forces page 0).
REQ-033 Simultaneous AHB write and VGA read of same word: VGA returns old data.

Reset
REQ-034 On HCLK edge with HRESETn=0: front=0, back=(PAGES>1?1:0), pending=0, HRDATA=0, HREADYOUT=1, IO_VGA_DATA=0, conflict state cleared, registered data phase cancelled (no write commits).
REQ-035 RAM contents SHALL NOT be cleared by reset.
REQ-036 Reset mid-transfer SHALL abort the transfer; the first accepted transfer after release behaves per REQ-021..REQ-024.

Verification
REQ-037 Reset release -> control read returns 0x001 (PAGES=2), FRONT_PAGE=0, FLIP_PENDING=0, HREADYOUT=1.
REQ-038 Write 0xABC to pixel 5, then back-to-back read pixel 5 -> one HREADYOUT=0 cycle, HRDATA=0xABC.
REQ-039 Write control 0x006 (back=0, req_front=1, flip) -> FLIP_PENDING=1; VSYNC pulse -> FRONT_PAGE=1, FLIP_PENDING=0.
REQ-040 Flip request write coincident with VSYNC -> FRONT_PAGE stays 0, FLIP_PENDING=1; next VSYNC -> FRONT_PAGE=1.
REQ-041 Page 1 pixel 7 = 0x123, page 0 pixel 7 = 0x456, FRONT_PAGE=1, IO_VGA_ADDR=7 -> IO_VGA_DATA=0x123 next cycle.
REQ-042 HRESETn low during write data phase to pixel 3 (old 0x111) -> pixel 3 reads 0x111 after release.
